// File: rtl/aes_fifo_sched_ctrl_pkg.sv
// Shared definitions for the AES FIFO scheduler controller and its FIFO.
package aes_fifo_sched_ctrl_pkg;

  // Width of one AES block.
  localparam int unsigned AES_BLK_W = 128;

  // FIFO depth shared by the FIFO instance and the controller's occupancy mirror.
  localparam int unsigned FIFO_DEPTH = 10;

  // Read sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    START,
    RUN
  } state_e;

endpackage

// File: rtl/aes_fifo_sched_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a rotating pointer.
module aes_fifo_sched_ctrl_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0] rr_ptr_q;
  logic [PtrW-1:0] rr_ptr_d;
  logic            found;
  int unsigned     idx;

  // First asserted request at or after rr_ptr, wrapping; next pointer is one past the winner.
  always_comb begin
    grant    = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (enable && !found && req[idx[PtrW-1:0]]) begin
        grant[idx[PtrW-1:0]] = 1'b1;
        rr_ptr_d             = PtrW'((idx + 1) % NUM_REQ);
        found                = 1'b1;
      end
    end
  end

  // Pointer moves only when the grant turned into a transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
    end else if (advance) begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/aes_fifo_sched_ctrl.sv
// Feeds the AES core from a flagless FIFO: arbitrates writers, mirrors occupancy,
// and sequences one read/start/done handshake per block.
module aes_fifo_sched_ctrl
  import aes_fifo_sched_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DEPTH   = FIFO_DEPTH,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*AES_BLK_W-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         fifo_write_en,
  output logic [AES_BLK_W-1:0]         fifo_data_in,
  output logic                         fifo_read_en,
  input  logic [AES_BLK_W-1:0]         fifo_data_out,
  output logic                         aes_start,
  output logic [AES_BLK_W-1:0]         aes_data,
  input  logic                         aes_busy,
  input  logic                         aes_done,
  output logic [CNT_W-1:0]             level,
  output logic                         full,
  output logic                         empty
);

  logic [CNT_W-1:0]     level_q, level_d;
  state_e               state_q, state_d;
  logic [AES_BLK_W-1:0] aes_data_q;

  // Usable capacity is DEPTH-1: the FIFO calls itself full when wr+1 == rd.
  assign full  = (level_q == CNT_W'(DEPTH - 1));
  assign empty = (level_q == '0);
  assign level = level_q;

  aes_fifo_sched_ctrl_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .enable  (!full),
    .advance (fifo_write_en),
    .grant   (req_ready)
  );

  assign fifo_write_en = |(req_valid & req_ready);

  // Route the granted requester's block; zero when nobody is granted.
  always_comb begin
    fifo_data_in = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        fifo_data_in = req_data[AES_BLK_W*i +: AES_BLK_W];
      end
    end
  end

  // Occupancy mirror; a same-cycle write and read cancel out.
  always_comb begin
    level_d = level_q;
    unique case ({fifo_write_en, fifo_read_en})
      2'b10:   level_d = level_q + CNT_W'(1);
      2'b01:   level_d = level_q - CNT_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Read sequencer next state and Moore outputs.
  always_comb begin
    state_d      = state_q;
    fifo_read_en = 1'b0;
    aes_start    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (level_q != '0 && !aes_busy) begin
          state_d = RD;
        end
      end
      RD: begin
        fifo_read_en = 1'b1;
        state_d      = CAP;
      end
      // FIFO read data is registered, so it is valid one cycle after the read.
      CAP: state_d = START;
      START: begin
        aes_start = 1'b1;
        state_d   = RUN;
      end
      // Done is only honoured here; a pulse coinciding with START is dropped.
      RUN: begin
        if (aes_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // Block presented to the core; held until the next capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aes_data_q <= '0;
    end else if (state_q == CAP) begin
      aes_data_q <= fifo_data_out;
    end
  end

  assign aes_data = aes_data_q;

endmodule

// File: tb/tb_aes_fifo_sched_ctrl.sv
module tb_aes_fifo_sched_ctrl;

  localparam int NR = 4;

  logic          clk;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [NR*128-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          fifo_write_en;
  logic [127:0]  fifo_data_in;
  logic          fifo_read_en;
  logic [127:0]  fifo_data_out;
  logic          aes_start;
  logic [127:0]  aes_data;
  logic          aes_busy;
  logic          aes_done;
  logic [3:0]    level;
  logic          full;
  logic          empty;

  int errors = 0;
  int checks = 0;

  aes_fifo_sched_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_read_en  (fifo_read_en),
    .fifo_data_out (fifo_data_out),
    .aes_start     (aes_start),
    .aes_data      (aes_data),
    .aes_busy      (aes_busy),
    .aes_done      (aes_done),
    .level         (level),
    .full          (full),
    .empty         (empty)
  );

  always #5 clk = ~clk;

  // Behavioural 10-entry FIFO with registered read data, sharing the reset.
  logic [127:0] fmem [10];
  logic [3:0]   fwr;
  logic [3:0]   frd;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwr           <= 4'd0;
      frd           <= 4'd0;
      fifo_data_out <= '0;
    end else begin
      if (fifo_write_en) begin
        fmem[fwr] <= fifo_data_in;
        fwr       <= (fwr == 4'd9) ? 4'd0 : fwr + 4'd1;
      end
      if (fifo_read_en) begin
        fifo_data_out <= fmem[frd];
        frd           <= (frd == 4'd9) ? 4'd0 : frd + 4'd1;
      end
    end
  end

  task automatic set_blk(input int i, input logic [127:0] v);
    req_data[128*i +: 128] = v;
  endtask

  // Reset for two cycles with the core busy, release on a falling edge.
  task automatic apply_reset();
    reset = 1'b0; req_valid = '0; aes_busy = 1'b1; aes_done = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [127:0] b [4];
    logic [3:0]   eg;
    for (int i = 0; i < 4; i++) begin
      b[i] = {4{32'hA000_0000 + 32'(i)}};
      set_blk(i, b[i]);
    end
    reset = 1'b0; req_valid = 4'b1111; aes_busy = 1'b1; aes_done = 1'b0;
    @(negedge clk); #1;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (aes_data !== 128'd0) begin errors++; $display("FAIL reset_aes_data got=%h exp=0", aes_data); end
    checks++; if ({aes_start, fifo_read_en} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b exp=00", {aes_start, fifo_read_en}); end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      eg = 4'b0001 << (k % 4);
      checks++; if (req_ready !== eg) begin errors++; $display("FAIL rr_grant_%0d got=%b exp=%b", k, req_ready, eg); end
      checks++; if (fifo_data_in !== b[k%4]) begin errors++; $display("FAIL rr_data_%0d got=%h exp=%h", k, fifo_data_in, b[k%4]); end
      @(negedge clk);
    end
    #1;
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL rr_level got=%0d exp=5", level); end
    req_valid = '0;
  endtask

  task automatic test_fill();
    int acc = 0;
    apply_reset();
    set_blk(0, 128'h5555);
    req_valid = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      #1; if (fifo_write_en) acc++;
      @(negedge clk);
    end
    #1;
    checks++; if (acc !== 9) begin errors++; $display("FAIL fill_accepted got=%0d exp=9", acc); end
    checks++; if (level !== 4'd9) begin errors++; $display("FAIL fill_level got=%0d exp=9", level); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL fill_ready got=%b exp=0000", req_ready); end
    checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("FAIL fill_wen got=%b exp=0", fifo_write_en); end
    checks++; if (fwr !== 4'd9) begin errors++; $display("FAIL fill_wr_ptr got=%0d exp=9", fwr); end
    req_valid = '0;
  endtask

  task automatic test_single();
    logic [127:0] a = 128'h00112233445566778899AABBCCDDEEFF;
    logic [127:0] c = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    apply_reset();
    aes_busy = 1'b0;
    set_blk(0, a); req_valid = 4'b0001; #1;
    checks++; if (fifo_write_en !== 1'b1) begin errors++; $display("FAIL single_wen got=%b exp=1", fifo_write_en); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (level !== 4'd1 || fifo_read_en !== 1'b0) begin errors++; $display("FAIL single_t1 got=%0d/%b exp=1/0", level, fifo_read_en); end
    @(negedge clk); #1;
    checks++; if (fifo_read_en !== 1'b1) begin errors++; $display("FAIL single_read got=%b exp=1", fifo_read_en); end
    @(negedge clk); #1;
    checks++; if ({fifo_read_en, aes_start} !== 2'b00 || level !== 4'd0) begin errors++; $display("FAIL single_cap got=%b/%0d exp=00/0", {fifo_read_en, aes_start}, level); end
    @(negedge clk); #1;
    checks++; if (aes_start !== 1'b1) begin errors++; $display("FAIL single_start got=%b exp=1", aes_start); end
    checks++; if (aes_data !== a) begin errors++; $display("FAIL single_data got=%h exp=%h", aes_data, a); end
    aes_done = 1'b1;  // coincides with START->RUN, must be ignored
    @(negedge clk); aes_done = 1'b0; set_blk(0, c); req_valid = 4'b0001; #1;
    checks++; if (aes_start !== 1'b0) begin errors++; $display("FAIL start_pulse_width got=%b exp=0", aes_start); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL second_level got=%0d exp=1", level); end
    @(negedge clk); #1;
    checks++; if (fifo_read_en !== 1'b0) begin errors++; $display("FAIL early_done_ignored got=%b exp=0", fifo_read_en); end
    aes_done = 1'b1;
    @(negedge clk); aes_done = 1'b0; #1;
    checks++; if (fifo_read_en !== 1'b0) begin errors++; $display("FAIL idle_no_read got=%b exp=0", fifo_read_en); end
    @(negedge clk); #1;
    checks++; if (fifo_read_en !== 1'b1) begin errors++; $display("FAIL second_read got=%b exp=1", fifo_read_en); end
    @(negedge clk); @(negedge clk); #1;
    checks++; if (aes_start !== 1'b1 || aes_data !== c) begin errors++; $display("FAIL second_start got=%b/%h exp=1/%h", aes_start, aes_data, c); end
    @(negedge clk); aes_done = 1'b1;
    @(negedge clk); aes_done = 1'b0; #1;
    checks++; if (aes_data !== c) begin errors++; $display("FAIL data_hold got=%h exp=%h", aes_data, c); end
  endtask

  task automatic test_full_read();
    apply_reset();
    set_blk(0, 128'h7777); req_valid = 4'b0001;
    for (int k = 0; k < 11; k++) @(negedge clk);
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fr_full got=%b exp=1", full); end
    aes_busy = 1'b0;
    @(negedge clk); #1;
    checks++; if (fifo_read_en !== 1'b1 || fifo_write_en !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL fr_rd_cycle got=%b%b%b exp=1 0 0000", fifo_read_en, fifo_write_en, req_ready); end
    @(negedge clk); aes_busy = 1'b1; #1;
    checks++; if (level !== 4'd8 || full !== 1'b0) begin errors++; $display("FAIL fr_level8 got=%0d/%b exp=8/0", level, full); end
    checks++; if (fifo_write_en !== 1'b1 || req_ready !== 4'b0001) begin errors++; $display("FAIL fr_regrant got=%b/%b exp=1/0001", fifo_write_en, req_ready); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (level !== 4'd9) begin errors++; $display("FAIL fr_refill got=%0d exp=9", level); end
  endtask

  task automatic test_simul();
    apply_reset();
    set_blk(0, 128'h3333); req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) @(negedge clk);
    req_valid = '0; #1;
    checks++; if (level !== 4'd3) begin errors++; $display("FAIL sim_pre got=%0d exp=3", level); end
    aes_busy = 1'b0;
    @(negedge clk); req_valid = 4'b0001; #1;
    checks++; if (fifo_read_en !== 1'b1 || fifo_write_en !== 1'b1) begin errors++; $display("FAIL sim_both got=%b%b exp=11", fifo_read_en, fifo_write_en); end
    @(negedge clk); req_valid = '0; aes_busy = 1'b1; #1;
    checks++; if (level !== 4'd3) begin errors++; $display("FAIL sim_level got=%0d exp=3", level); end
  endtask

  task automatic test_reset_run();
    logic [127:0] d = 128'hCAFE_0000_1111_2222_3333_4444_5555_6666;
    bit saw = 1'b0;
    apply_reset();
    set_blk(0, d); req_valid = 4'b0001;
    for (int k = 0; k < 6; k++) @(negedge clk);
    req_valid = '0; aes_busy = 1'b0;
    @(negedge clk); aes_busy = 1'b1;
    for (int k = 0; k < 3; k++) @(negedge clk);
    #1;
    checks++; if (level !== 4'd5 || aes_data !== d) begin errors++; $display("FAIL run_pre got=%0d/%h exp=5/%h", level, aes_data, d); end
    #1; reset = 1'b0; #1;
    checks++; if (level !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL async_level got=%0d/%b exp=0/1", level, empty); end
    checks++; if (aes_data !== 128'd0 || aes_start !== 1'b0 || fifo_read_en !== 1'b0) begin errors++; $display("FAIL async_outs got=%h/%b/%b exp=0/0/0", aes_data, aes_start, fifo_read_en); end
    @(negedge clk); reset = 1'b1; aes_busy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1; if (fifo_read_en) saw = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL post_reset_read got=%b exp=0", saw); end
    req_valid = 4'b0001;
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    checks++; if (fifo_read_en !== 1'b1) begin errors++; $display("FAIL post_reset_new got=%b exp=1", fifo_read_en); end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; req_valid = '0; req_data = '0;
    aes_busy = 1'b1; aes_done = 1'b0;
    test_reset();
    test_fill();
    test_single();
    test_full_read();
    test_simul();
    test_reset_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
